// File: rtl/rv_mul_pkg.sv
// Shared encodings and defaults for the RV64 M-extension multiply sequencer.
package rv_mul_pkg;

  localparam logic [2:0] MUL_F3_MUL    = 3'b000;
  localparam logic [2:0] MUL_F3_MULH   = 3'b001;
  localparam logic [2:0] MUL_F3_MULHSU = 3'b010;
  localparam logic [2:0] MUL_F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_W,
    SEL_ZERO
  } sel_e;

  localparam int DEF_LAT   = 3;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_W = 5;

endpackage

// File: rtl/rv_mul_core.sv
// 65x65 signed multiplier, LAT register stages, product valid LAT cycles after inputs.
// Data-only: never stalls, no reset; validity is tracked by the controller.
module rv_mul_core #(
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic signed [64:0]  a,
  input  logic signed [64:0]  b,
  output logic signed [129:0] p
);

  logic signed [129:0] a_x;
  logic signed [129:0] b_x;
  logic signed [129:0] stg_q [LAT];

  assign a_x = {{65{a[64]}}, a};
  assign b_x = {{65{b[64]}}, b};

  always_ff @(posedge clk) begin
    stg_q[0] <= a_x * b_x;
    for (int i = 1; i < LAT; i++) begin
      stg_q[i] <= stg_q[i-1];
    end
  end

  assign p = stg_q[LAT-1];

endmodule

// File: rtl/rv_mul_ctrl.sv
// Multiply-group sequencer: accept at credit, LAT-cycle pipe, in-order FWFT result buffer with bypass.
// Consumer backpressure only throttles req_ready_o via credits. Optional counters: RV_MUL_PERF_EN.
module rv_mul_ctrl
  import rv_mul_pkg::*;
#(
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic             req_word_i,
  input  logic [63:0]      req_op1_i,
  input  logic [63:0]      req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [63:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic [31:0]      perf_ops_o,
  output logic [31:0]      perf_stall_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   buf_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LAT-1:0]     stg_vld_q;
  logic [TAG_W-1:0]   stg_tag_q [LAT];
  sel_e               stg_sel_q [LAT];
  logic [63:0]        buf_res_q [DEPTH];
  logic [TAG_W-1:0]   buf_tag_q [DEPTH];

  logic               accept;
  logic               pop;
  logic               pop_buf;
  logic               push;
  logic               buf_empty;
  logic               op1_signed;
  logic               op2_signed;
  logic signed [64:0] op_a;
  logic signed [64:0] op_b;
  logic signed [129:0] prod;
  logic               unused_prod_hi;
  sel_e               req_sel;
  logic               fin_vld;
  logic [63:0]        fin_res;

  assign req_ready_o = !rst && !flush_i && (outstanding_q < CNT_FULL);
  assign accept      = req_valid_i && req_ready_o;

  assign op1_signed = (req_funct3_i != MUL_F3_MULHU);
  assign op2_signed = (req_funct3_i == MUL_F3_MUL) || (req_funct3_i == MUL_F3_MULH);
  assign op_a       = {op1_signed & req_op1_i[63], req_op1_i};
  assign op_b       = {op2_signed & req_op2_i[63], req_op2_i};

  always_comb begin
    req_sel = SEL_HI;
    if (req_word_i)                        req_sel = SEL_W;
    else if (req_funct3_i[2])              req_sel = SEL_ZERO;
    else if (req_funct3_i == MUL_F3_MUL)   req_sel = SEL_LO;
  end

  rv_mul_core #(.LAT(LAT)) u_core (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .p   (prod)
  );

  // Bits above 127 only carry sign information no result ever selects.
  assign unused_prod_hi = ^prod[129:128];

  assign fin_vld = stg_vld_q[LAT-1];

  always_comb begin
    fin_res = '0;
    case (stg_sel_q[LAT-1])
      SEL_LO:  fin_res = prod[63:0];
      SEL_HI:  fin_res = prod[127:64];
      SEL_W:   fin_res = {{32{prod[31]}}, prod[31:0]};
      default: fin_res = '0;
    endcase
  end

  assign buf_empty   = (buf_cnt_q == '0);
  assign rsp_valid_o = !rst && !flush_i && (!buf_empty || fin_vld);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign pop_buf     = pop && !buf_empty;
  // Final stage goes straight out when the buffer is empty and the consumer takes it.
  assign push        = fin_vld && !(buf_empty && rsp_ready_i);

  always_comb begin
    rsp_result_o = '0;
    rsp_tag_o    = '0;
    if (rsp_valid_o) begin
      if (buf_empty) begin
        rsp_result_o = fin_res;
        rsp_tag_o    = stg_tag_q[LAT-1];
      end else begin
        rsp_result_o = buf_res_q[rd_ptr_q];
        rsp_tag_o    = buf_tag_q[rd_ptr_q];
      end
    end
  end

  assign busy_o = !rst && (outstanding_q != '0);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      stg_vld_q <= '0;
    end else begin
      stg_vld_q[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    stg_tag_q[0] <= req_tag_i;
    stg_sel_q[0] <= req_sel;
    for (int i = 1; i < LAT; i++) begin
      stg_tag_q[i] <= stg_tag_q[i-1];
      stg_sel_q[i] <= stg_sel_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      buf_cnt_q     <= '0;
      outstanding_q <= '0;
    end else begin
      if (push)    wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop_buf) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      if (push && !pop_buf)      buf_cnt_q <= buf_cnt_q + CNT_ONE;
      else if (!push && pop_buf) buf_cnt_q <= buf_cnt_q - CNT_ONE;
      if (accept && !pop)        outstanding_q <= outstanding_q + CNT_ONE;
      else if (!accept && pop)   outstanding_q <= outstanding_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_res_q[wr_ptr_q] <= fin_res;
      buf_tag_q[wr_ptr_q] <= stg_tag_q[LAT-1];
    end
  end

`ifdef RV_MUL_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && (perf_ops_q != '1)) perf_ops_q <= perf_ops_q + 32'd1;
      if (req_valid_i && !req_ready_o && !flush_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops_o   = rst ? '0 : perf_ops_q;
  assign perf_stall_o = rst ? '0 : perf_stall_q;
`else
  assign perf_ops_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_rv_mul_ctrl.sv
// Self-checking bench for rv_mul_ctrl: vector table plus backpressure, flush and reset sequences.
module tb_rv_mul_ctrl;
  import rv_mul_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_funct3_i;
  logic             req_word_i;
  logic [63:0]      req_op1_i;
  logic [63:0]      req_op2_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [63:0]      rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o;
  logic [31:0]      perf_ops_o;
  logic [31:0]      perf_stall_o;

  rv_mul_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_funct3_i (req_funct3_i),
    .req_word_i   (req_word_i),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .req_tag_i    (req_tag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_tag_o    (rsp_tag_o),
    .busy_o       (busy_o),
    .perf_ops_o   (perf_ops_o),
    .perf_stall_o (perf_stall_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_count = 0;
  bit chk_lat  = 1'b0;
  logic [63:0] drv_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      res;
    int               acc_cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst) begin
      sb_q.delete();
    end else if (flush_i) begin
      chk("flush_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      sb_q.delete();
    end else begin
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_count++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got tag %0d result %h, expected no response", rsp_tag_o, rsp_result_o);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_tag", {59'd0, rsp_tag_o}, {59'd0, e.tag});
          chk("rsp_result", rsp_result_o, e.res);
          if (chk_lat) chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(LAT));
        end
      end
      if (req_valid_i && req_ready_o) sb_q.push_back('{req_tag_i, drv_exp, cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] t, input logic [63:0] e);
    req_valid_i  = 1'b1;
    req_funct3_i = f3;
    req_word_i   = w;
    req_op1_i    = a;
    req_op2_i    = b;
    req_tag_i    = t;
    drv_exp      = e;
  endtask

  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] t, input logic [63:0] e);
    bit acc;
    acc = 1'b0;
    drive(f3, w, a, b, t, e);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready_o;
      step();
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: tag %0d never accepted, expected acceptance", t);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) step();
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin : stim
    int idx;
    int stalls;
    int snap;
    logic [31:0] exp_stall;
    logic [31:0] exp_ops;

    vecs[0]  = '{MUL_F3_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1]  = '{MUL_F3_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[2]  = '{MUL_F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{MUL_F3_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4]  = '{MUL_F3_MUL,    1'b1, 64'h0000_0001_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000};
    vecs[5]  = '{MUL_F3_MUL,    1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0};
    vecs[6]  = '{MUL_F3_MULHU,  1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1};
    vecs[7]  = '{MUL_F3_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[8]  = '{MUL_F3_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{3'b100,        1'b0, 64'd5, 64'd6, 64'h0};
    vecs[10] = '{MUL_F3_MUL,    1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1};
    vecs[11] = '{3'b101,        1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[12] = '{MUL_F3_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1};

`ifdef RV_MUL_PERF_EN
    exp_stall = 32'd5;
    exp_ops   = 32'd4;
`else
    exp_stall = 32'd0;
    exp_ops   = 32'd0;
`endif

    rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_funct3_i = '0; req_word_i = 1'b0;
    req_op1_i = '0; req_op2_i = '0; req_tag_i = '0; rsp_ready_i = 1'b1;
    step();
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_rsp_result", rsp_result_o, 64'd0);
    chk("rst_perf_ops", {32'd0, perf_ops_o}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, req_ready_o}, 64'd1);
    step();

    // Single MUL with latency check, then the vector table back-to-back.
    chk_lat = 1'b1;
    issue(MUL_F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    req_valid_i = 1'b0;
    wait_drain();
    for (int i = 0; i < 13; i++)
      issue(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, TAG_W'(i + 10), vecs[i].exp);
    req_valid_i = 1'b0;
    wait_drain();

    // Backpressure: credits cap acceptance at DEPTH, head result holds stable.
    chk_lat = 1'b0;
    rsp_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) drive(MUL_F3_MUL, 1'b0, 64'(idx + 2), 64'(idx + 3), TAG_W'(idx), 64'((idx + 2) * (idx + 3)));
      @(negedge clk);
      if (req_valid_i && req_ready_o) idx++;
      if (c == 6 || c == 9) begin
        chk("bp_head_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("bp_head_tag", {59'd0, rsp_tag_o}, 64'd0);
        chk("bp_head_result", rsp_result_o, 64'd6);
      end
      step();
    end
    chk("bp_accepted", 64'(idx), 64'd4);
    @(negedge clk);
    chk("bp_ready_low", {63'd0, req_ready_o}, 64'd0);
    step();
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      drive(MUL_F3_MUL, 1'b0, 64'(idx + 2), 64'(idx + 3), TAG_W'(idx), 64'((idx + 2) * (idx + 3)));
      @(negedge clk);
      if (req_ready_o) idx++;
      step();
    end
    req_valid_i = 1'b0;
    chk("bp_total_accepted", 64'(idx), 64'd6);
    wait_drain();

    // Flush with three ops in flight; a request presented during flush must not enter.
    chk_lat = 1'b1;
    issue(MUL_F3_MUL, 1'b0, 64'd2, 64'd2, 5'd1, 64'd4);
    issue(MUL_F3_MUL, 1'b0, 64'd3, 64'd3, 5'd2, 64'd9);
    issue(MUL_F3_MUL, 1'b0, 64'd4, 64'd4, 5'd3, 64'd16);
    flush_i = 1'b1;
    drive(MUL_F3_MUL, 1'b0, 64'd5, 64'd5, 5'd30, 64'd25);
    @(negedge clk);
    chk("flush_req_ready", {63'd0, req_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_clear", {63'd0, busy_o}, 64'd0);
    snap = rsp_count;
    step();
    issue(MUL_F3_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
    req_valid_i = 1'b0;
    wait_drain();
    for (int k = 0; k < 6; k++) step();
    chk("flush_only_one_rsp", 64'(rsp_count - snap), 64'd1);

    // Reset with two results buffered, then count stall cycles.
    chk_lat = 1'b0;
    rsp_ready_i = 1'b0;
    issue(MUL_F3_MUL, 1'b0, 64'd11, 64'd11, 5'd20, 64'd121);
    issue(MUL_F3_MUL, 1'b0, 64'd12, 64'd12, 5'd21, 64'd144);
    req_valid_i = 1'b0;
    for (int k = 0; k < LAT + 1; k++) step();
    @(negedge clk);
    chk("pre_rst_valid", {63'd0, rsp_valid_o}, 64'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_tag", {59'd0, rsp_tag_o}, 64'd0);
    chk("mid_rst_perf_ops", {32'd0, perf_ops_o}, 64'd0);
    chk("mid_rst_perf_stall", {32'd0, perf_stall_o}, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rel_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    step();
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 30 && stalls < 5; c++) begin
      drive(MUL_F3_MUL, 1'b0, 64'(idx + 2), 64'(idx + 3), TAG_W'(idx), 64'((idx + 2) * (idx + 3)));
      @(negedge clk);
      if (req_ready_o) idx++;
      else stalls++;
      step();
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("perf_stall", {32'd0, perf_stall_o}, {32'd0, exp_stall});
    chk("perf_ops", {32'd0, perf_ops_o}, {32'd0, exp_ops});
    chk("stall_accepts", 64'(idx), 64'd4);
    step();
    rsp_ready_i = 1'b1;
    wait_drain();
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    chk("final_busy", {63'd0, busy_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rv_mul_ctrl.md
Name: rv_mul_ctrl

Overview:
- Sequences the 3-stage pipelined multiplier datapath for the RV64 M-extension multiply group: MUL, MULH, MULHSU, MULHU, MULW.
- Sits between the issue stage and writeback.
- Accepts requests over a valid/ready handshake, formats operands, and tracks in-flight ops with tags.
- Returns results in order through a credit-limited result buffer; supports pipeline flush.

Parameters:
- LAT, 3, multiplier pipeline register stages (acceptance to result); minimum 1.
- DEPTH, 4, maximum outstanding ops (in-flight plus buffered); must be >= LAT.
- TAG_W, 5, width of the request tag echoed with the result.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- flush_i  input  1  squash all outstanding ops.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request can be accepted.
- req_funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- req_word_i  input  1  1 = MULW.
- req_op1_i  input  64  rs1 value.
- req_op2_i  input  64  rs2 value.
- req_tag_i  input  TAG_W  destination tag.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_result_o  output  64  result.
- rsp_tag_o  output  TAG_W  tag of result.
- busy_o  output  1  any op outstanding.
- perf_ops_o  output  32  accepted-op counter.
- perf_stall_o  output  32  request-stall cycle counter.

Behaviour:
- Reset: while rst=1, req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_tag_o=0, busy_o=0, and perf counters are cleared. All stage valids, buffer pointers and the outstanding counter are cleared. Reset mid-operation discards everything.
- Accept when req_valid_i & req_ready_o.
- req_ready_o = !rst & !flush_i & (outstanding < DEPTH). It has no combinational dependence on rsp_ready_i.
- Operand formatting to 65 bits:
  - op1 sign-extended for MUL, MULH, MULHSU; zero-extended for MULHU.
  - op2 sign-extended for MUL, MULH; zero-extended for MULHSU, MULHU.
  - Signed 65x65 product, 130 bits.
- Result select:
  - MUL: P[63:0].
  - MULH, MULHSU, MULHU: P[127:64].
  - req_word_i=1 (any funct3): sign-extend P[31:0] to 64 bits.
  - req_funct3_i[2]=1 with req_word_i=0: result 0, still accepted and ordered.
- Valid/tag/select shift registers run alongside the datapath for LAT stages. The pipeline never stalls.
- Result buffer: in-order FIFO of DEPTH entries, first-word-fall-through.
  - When the buffer is empty, the final stage bypasses to the outputs.
  - An op accepted in cycle N presents rsp_valid_o in cycle N+LAT if no older result is pending.
  - A final-stage result is pushed only if not consumed via bypass.
  - With rsp_ready_i held high and back-to-back requests, throughput is 1 op/cycle.
- Response handshake:
  - rsp_valid_o, rsp_result_o and rsp_tag_o hold stable while rsp_valid_o & !rsp_ready_i.
  - Pop occurs on rsp_valid_o & rsp_ready_i.
- Outstanding counter: +1 on accept, -1 on response handshake, unchanged when both occur in the same cycle.
  - Buffer overflow is impossible by credit.
  - Push and pop on a full buffer in the same cycle is legal.
- Flush:
  - In a flush_i cycle, rsp_valid_o=0 and no accept occurs.
  - On the next edge, all stage valids, the buffer and the counter clear.
  - Flush and rst together behave as rst.
- busy_o = (outstanding != 0).
- Pointers wrap modulo DEPTH. DEPTH is not restricted to a power of two; use explicit wrap compare.

Optional Feature:
- Macro RV_MUL_PERF_EN.
- Defined:
  - perf_ops_o increments on every accept.
  - perf_stall_o increments every cycle with req_valid_i & !req_ready_o & !flush_i.
  - Both counters saturate at 0xFFFF_FFFF and clear on rst only.
- Undefined: both ports are constant 0, no counter flops, and the ports remain present.

Decomposition:
- Package rv_mul_pkg holds:
  - funct3 encodings as localparams: MUL_F3_MUL, MUL_F3_MULH, MUL_F3_MULHSU, MUL_F3_MULHU.
  - Result-select enum: SEL_LO, SEL_HI, SEL_W, SEL_ZERO.
  - Default LAT, DEPTH and TAG_W.
- Sub-module rv_mul_core:
  - 65x65 signed multiplier, LAT register stages, data-only, no reset on data.
  - rv_mul_ctrl owns valids, tags, select, FIFO and credits.

Test Plan:
- MUL, op1=7, op2=0xFFFF_FFFF_FFFF_FFFD, tag=3 -> rsp_valid_o exactly 3 cycles after accept, result 0xFFFF_FFFF_FFFF_FFEB, tag 3.
- op1=op2=0xFFFF_FFFF_FFFF_FFFF issued back-to-back as MULH, MULHSU, MULHU -> 0x0, then 0xFFFF_FFFF_FFFF_FFFF, then 0xFFFF_FFFF_FFFF_FFFE, on consecutive cycles.
- MULW, op1=0x0000_0001_4000_0000, op2=2 -> 0xFFFF_FFFF_8000_0000.
- rsp_ready_i=0 with 6 back-to-back requests, tags 0-5 -> exactly 4 accepted, req_ready_o=0 afterwards. Raise rsp_ready_i -> responses in order with tags 0,1,2,3, then tags 4,5 accepted and returned.
- Flush with 3 ops in flight -> none of them respond and busy_o drops next cycle. A request with tag 9 issued after the flush responds alone, LAT cycles later.
- rst asserted mid-stream with 2 results buffered -> rsp_valid_o=0 and perf counters 0. After release, req_ready_o=1, and with RV_MUL_PERF_EN, 5 stall cycles are counted as perf_stall_o=5.
